// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
// ID/EX pipeline register plus the EX operand-select stage that feeds the ALU.
// The decoded instruction is captured on the rising clock edge. The two ALU
// source buses are then built from the registered operands.
//
// Optional feature macro: ID_EX_FWD_EN
//   defined   : EX/MEM and MEM/WB results are forwarded onto the operand buses.
//               hazard_o covers load-use only.
//   undefined : there are no forwarding muxes. hazard_o also stalls on any
//               pending EX or EX/MEM writer of an ID source register.
//               MEM/WB is covered by the write-first register file.
//
// Capture priority: rst_i > flush_i > stall_i > hazard_o > normal.
// A bubble is bit-identical to the reset state.
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_AW-1:0] id_rs_addr_i,
    input  logic [REG_AW-1:0] id_rt_addr_i,
    input  logic [REG_AW-1:0] id_rd_addr_i,
    input  logic [3:0]        id_alu_op_i,
    input  logic              id_alu_src_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              id_mem_write_i,
    input  logic              id_mem_to_reg_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [3:0]        alu_op_o,
    output logic [DATA_W-1:0] ex_store_data_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_valid_o,
    output logic              ex_reg_write_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic              ex_mem_to_reg_o,
    output logic              hazard_o
);

    // One ID/EX entry. The all-zero value is both the reset state and the bubble.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic [REG_AW-1:0] rd_addr;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [3:0]        alu_op;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } stage_t;

    stage_t            stage_q;
    stage_t            stage_d;
    logic              hazard_s;
    logic [DATA_W-1:0] fwd_rs_s;
    logic [DATA_W-1:0] fwd_rt_s;

    // True when a non-zero destination register matches either ID source register.
    function automatic logic dest_hits_src(
        input logic [REG_AW-1:0] dest,
        input logic [REG_AW-1:0] src_a,
        input logic [REG_AW-1:0] src_b
    );
        dest_hits_src = (dest != {REG_AW{1'b0}}) && ((dest == src_a) || (dest == src_b));
    endfunction

`ifdef ID_EX_FWD_EN
    // Operand forwarding. EX/MEM is younger, so it wins over MEM/WB.
    // Register 0 is never forwarded.
    function automatic logic [DATA_W-1:0] fwd_operand(
        input logic [REG_AW-1:0] src_addr,
        input logic [DATA_W-1:0] reg_data,
        input logic              em_we,
        input logic [REG_AW-1:0] em_rd,
        input logic [DATA_W-1:0] em_result,
        input logic              mw_we,
        input logic [REG_AW-1:0] mw_rd,
        input logic [DATA_W-1:0] mw_data
    );
        if (em_we && (em_rd != {REG_AW{1'b0}}) && (em_rd == src_addr)) begin
            fwd_operand = em_result;
        end else if (mw_we && (mw_rd != {REG_AW{1'b0}}) && (mw_rd == src_addr)) begin
            fwd_operand = mw_data;
        end else begin
            fwd_operand = reg_data;
        end
    endfunction
`endif

    // Hazard detection: the ID instruction must wait for a producer still in flight.
    always_comb begin
        hazard_s = 1'b0;
        if (rst_i || !id_valid_i) begin
            hazard_s = 1'b0;
        end else begin
            hazard_s = stage_q.valid && stage_q.mem_read &&
                       dest_hits_src(stage_q.rd_addr, id_rs_addr_i, id_rt_addr_i);
`ifndef ID_EX_FWD_EN
            // Without forwarding, any result not yet in the register file blocks ID.
            hazard_s = hazard_s ||
                       (stage_q.valid && stage_q.reg_write &&
                        dest_hits_src(stage_q.rd_addr, id_rs_addr_i, id_rt_addr_i)) ||
                       (exmem_reg_write_i &&
                        dest_hits_src(exmem_rd_i, id_rs_addr_i, id_rt_addr_i));
`endif
        end
    end

    // Next-entry selection: flush beats stall, stall beats hazard bubble, then normal capture.
    always_comb begin
        stage_d = stage_q;
        if (flush_i) begin
            stage_d = '0;
        end else if (stall_i) begin
            stage_d = stage_q;
        end else if (hazard_s) begin
            stage_d = '0;
        end else begin
            stage_d.valid      = id_valid_i;
            stage_d.rs_addr    = id_rs_addr_i;
            stage_d.rt_addr    = id_rt_addr_i;
            stage_d.rd_addr    = id_rd_addr_i;
            stage_d.rs_data    = id_rs_data_i;
            stage_d.rt_data    = id_rt_data_i;
            stage_d.imm        = id_imm_i;
            // A non-instruction carries data but no side-effecting controls.
            stage_d.alu_op     = id_valid_i ? id_alu_op_i : 4'd0;
            stage_d.alu_src    = id_valid_i & id_alu_src_i;
            stage_d.reg_write  = id_valid_i & id_reg_write_i;
            stage_d.mem_read   = id_valid_i & id_mem_read_i;
            stage_d.mem_write  = id_valid_i & id_mem_write_i;
            stage_d.mem_to_reg = id_valid_i & id_mem_to_reg_i;
        end
    end

    // ID/EX pipeline register. An asynchronous reset clears the entry immediately, even while stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

`ifdef ID_EX_FWD_EN
    // Forwarded rs/rt operands.
    always_comb begin
        fwd_rs_s = fwd_operand(stage_q.rs_addr, stage_q.rs_data,
                               exmem_reg_write_i, exmem_rd_i, exmem_result_i,
                               memwb_reg_write_i, memwb_rd_i, memwb_data_i);
        fwd_rt_s = fwd_operand(stage_q.rt_addr, stage_q.rt_data,
                               exmem_reg_write_i, exmem_rd_i, exmem_result_i,
                               memwb_reg_write_i, memwb_rd_i, memwb_data_i);
    end
`else
    // Without forwarding, the operands are the registered read data.
    always_comb begin
        fwd_rs_s = stage_q.rs_data;
        fwd_rt_s = stage_q.rt_data;
    end

    // These inputs and fields matter only when forwarding is built in.
    logic unused_s;
    assign unused_s = ^{exmem_result_i, memwb_reg_write_i, memwb_rd_i, memwb_data_i,
                        stage_q.rs_addr, stage_q.rt_addr};
`endif

    assign alu_src1_o      = fwd_rs_s;
    assign alu_src2_o      = stage_q.alu_src ? stage_q.imm : fwd_rt_s;
    assign ex_store_data_o = fwd_rt_s;
    assign alu_op_o        = stage_q.alu_op;
    assign ex_rd_o         = stage_q.rd_addr;
    assign ex_valid_o      = stage_q.valid;
    assign ex_reg_write_o  = stage_q.reg_write;
    assign ex_mem_read_o   = stage_q.mem_read;
    assign ex_mem_write_o  = stage_q.mem_write;
    assign ex_mem_to_reg_o = stage_q.mem_to_reg;
    assign hazard_o        = hazard_s;

endmodule
